// File: rtl/turn_timer_p.sv
// Countdown turn timer: a prescaler divides clk_i down to one-second steps, and the count runs
// from START_SEC to zero. It supports pause, abort, optional auto-reload and a warning window.
module turn_timer_p #(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned START_SEC   = 10,
  parameter int unsigned WARN_SEC    = 3,
  parameter int unsigned CNT_W       = 4,
  parameter int unsigned AUTO_RELOAD = 0
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             pause_i,
  input  logic             stop_i,
  output logic [CNT_W-1:0] count_o,
  output logic             tick_o,
  output logic             warning_o,
  output logic             expired_o,
  output logic             expired_pulse_o,
  output logic             running_o
);

  localparam int unsigned PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PRE_W-1:0] PreMax   = PRE_W'(CLK_HZ - 1);
  localparam logic [CNT_W-1:0] CntStart = CNT_W'(START_SEC);
  localparam logic [CNT_W-1:0] CntWarn  = CNT_W'(WARN_SEC);

  typedef enum logic [1:0] {StIdle, StRun, StPaused, StExpired} state_e;

  state_e           state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             tick_q, tick_d;
  logic             ep_q, ep_d;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      pre_q   <= '0;
      count_q <= CntStart;
      tick_q  <= 1'b0;
      ep_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      count_q <= count_d;
      tick_q  <= tick_d;
      ep_q    <= ep_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    count_d = count_q;
    tick_d  = 1'b0;
    ep_d    = 1'b0;
    if (stop_i) begin
      state_d = StIdle;
      pre_d   = '0;
      count_d = CntStart;
    end else if (start_i) begin
      // Start also pre-empts a wrap in the same cycle, so no pulse is raised here.
      state_d = StRun;
      pre_d   = '0;
      count_d = CntStart;
    end else begin
      unique case (state_q)
        StIdle: begin
          pre_d   = '0;
          count_d = CntStart;
        end
        StRun: begin
          if (pre_q == PreMax) begin
            pre_d  = '0;
            tick_d = 1'b1;
            if (count_q <= CNT_W'(1)) begin
              ep_d = 1'b1;
              if (AUTO_RELOAD != 0) begin
                count_d = CntStart;
              end else begin
                count_d = '0;
                state_d = StExpired;
              end
            end else begin
              count_d = count_q - CNT_W'(1);
            end
          end else begin
            pre_d = pre_q + PRE_W'(1);
          end
          // A pause sampled on a wrap still lets that decrement land first.
          if (pause_i && state_d == StRun) begin
            state_d = StPaused;
          end
        end
        StPaused: begin
          if (!pause_i) begin
            state_d = StRun;
          end
        end
        StExpired: begin
          pre_d   = '0;
          count_d = '0;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign count_o         = count_q;
  assign tick_o          = tick_q;
  assign expired_pulse_o = ep_q;
  assign running_o       = (state_q == StRun);
  assign expired_o       = (state_q == StExpired);
  assign warning_o       = ((state_q == StRun) || (state_q == StPaused)) &&
                           (count_q != '0) && (count_q <= CntWarn);

endmodule

// File: tb/tb_turn_timer_p.sv
// Bench for turn_timer_p: one instance without auto-reload and one with it, both fed the same
// stimulus. Each is checked every cycle against a model built on elapsed running cycles.
module tb_turn_timer_p;

  localparam int unsigned HZ = 4;
  localparam int unsigned ST = 3;
  localparam int unsigned WS = 2;
  localparam int unsigned CW = 2;

  localparam int MIdle = 0;
  localparam int MRun = 1;
  localparam int MPaused = 2;
  localparam int MExpired = 3;

  logic clk = 1'b0;
  logic reset_i, start_i, pause_i, stop_i;

  logic [CW-1:0] count_a, count_b;
  logic tick_a, warn_a, exp_a, ep_a, run_a;
  logic tick_b, warn_b, exp_b, ep_b, run_b;

  turn_timer_p #(.CLK_HZ(HZ), .START_SEC(ST), .WARN_SEC(WS), .CNT_W(CW), .AUTO_RELOAD(0)) u_dut_a (
    .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .pause_i(pause_i), .stop_i(stop_i),
    .count_o(count_a), .tick_o(tick_a), .warning_o(warn_a), .expired_o(exp_a),
    .expired_pulse_o(ep_a), .running_o(run_a)
  );

  turn_timer_p #(.CLK_HZ(HZ), .START_SEC(ST), .WARN_SEC(WS), .CNT_W(CW), .AUTO_RELOAD(1)) u_dut_b (
    .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .pause_i(pause_i), .stop_i(stop_i),
    .count_o(count_b), .tick_o(tick_b), .warning_o(warn_b), .expired_o(exp_b),
    .expired_pulse_o(ep_b), .running_o(run_b)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Model: mode plus the number of running cycles since the last start.
  int mode[2];
  int run_cyc[2];
  bit m_tick[2];
  bit m_ep[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model_count(input int k);
    if (mode[k] == MIdle) return ST;
    if (mode[k] == MExpired) return 0;
    if (k == 1) return ST - (run_cyc[k] / HZ) % ST;
    return ST - run_cyc[k] / HZ;
  endfunction

  task automatic model_step(input int k);
    m_tick[k] = 1'b0;
    m_ep[k] = 1'b0;
    if (reset_i || stop_i) begin
      mode[k] = MIdle;
      run_cyc[k] = 0;
    end else if (start_i) begin
      mode[k] = MRun;
      run_cyc[k] = 0;
    end else if (mode[k] == MRun) begin
      run_cyc[k]++;
      if (run_cyc[k] % HZ == 0) begin
        m_tick[k] = 1'b1;
        if ((run_cyc[k] / HZ) % ST == 0) begin
          m_ep[k] = 1'b1;
          if (k == 0) mode[k] = MExpired;
        end
      end
      if (mode[k] == MRun && pause_i) mode[k] = MPaused;
    end else if (mode[k] == MPaused && !pause_i) begin
      mode[k] = MRun;
    end
  endtask

  task automatic check_dut(input int k, input logic [CW-1:0] c, input logic t, input logic w,
                           input logic e, input logic p, input logic r);
    int ec;
    ec = model_count(k);
    chk($sformatf("count%0d", k), 32'(c), ec);
    chk($sformatf("tick%0d", k), 32'(t), 32'(m_tick[k]));
    chk($sformatf("expired_pulse%0d", k), 32'(p), 32'(m_ep[k]));
    chk($sformatf("expired%0d", k), 32'(e), 32'(mode[k] == MExpired));
    chk($sformatf("running%0d", k), 32'(r), 32'(mode[k] == MRun));
    chk($sformatf("warning%0d", k), 32'(w),
        32'((mode[k] == MRun || mode[k] == MPaused) && ec >= 1 && ec <= WS));
  endtask

  task automatic cycle(input bit rs, input bit st, input bit sp, input bit pa);
    reset_i = rs;
    start_i = st;
    stop_i = sp;
    pause_i = pa;
    @(posedge clk);
    #1;
    model_step(0);
    model_step(1);
    check_dut(0, count_a, tick_a, warn_a, exp_a, ep_a, run_a);
    check_dut(1, count_b, tick_b, warn_b, exp_b, ep_b, run_b);
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bit pa;
    reset_i = 1'b1;
    start_i = 1'b0;
    stop_i = 1'b0;
    pause_i = 1'b0;
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk("reset_count", 32'(count_a), 32'd3);
    idle_n(2);

    // Full countdown to expiry, then hold.
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    chk("start_running", 32'(run_a), 32'd1);
    idle_n(15);
    chk("expired_hold", 32'(exp_a), 32'd1);

    // Restart from expired, then abort with stop.
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    idle_n(5);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    chk("stop_idle_count", 32'(count_a), 32'd3);

    // Pause for ten cycles after the second clock of a run.
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("paused_count", 32'(count_a), 32'd3);
    idle_n(6);

    // Start with stop wins for stop; start on a wrap cycle suppresses the tick.
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    chk("start_stop_idle", 32'(run_a), 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    idle_n(3);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    chk("wrap_start_tick", 32'(tick_a), 32'd0);
    chk("wrap_start_count", 32'(count_a), 32'd3);

    // Reset while count shows 1.
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    idle_n(8);
    chk("pre_reset_count", 32'(count_a), 32'd1);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    chk("mid_reset_count", 32'(count_a), 32'd3);
    chk("mid_reset_running", 32'(run_a), 32'd0);

    // Random traffic.
    pa = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(14) == 0) pa = ~pa;
      cycle($urandom_range(199) == 0, $urandom_range(24) == 0, $urandom_range(59) == 0, pa);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
